// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared constants for the I2C bus front-end: default synchroniser depth,
// default debounce counter width and the idle (released) line level.
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int I2C_SYNC_STAGES = 2;
    localparam int I2C_DBC_W       = 14;

    // Both I2C lines idle high (pull-ups), so every reset value uses this.
    localparam logic I2C_IDLE = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// ---------------------------------------------------------------------------
// i2c_glitch_filter
// Synchronises one raw I2C pad line and debounces it. The filtered level only
// follows the synchronised input after it has differed for debounce_cnt+1
// consecutive cycles.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   srstn        synchronous active-low soft reset
//   din          raw pad input (asynchronous to clk)
//   debounce_cnt stability cycles required before level changes
//   level        filtered, registered line level
// ---------------------------------------------------------------------------
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int DBC_W       = I2C_DBC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             srstn,
    input  logic             din,
    input  logic [DBC_W-1:0] debounce_cnt,
    output logic             level
);

    localparam logic [DBC_W-1:0] CNT_ZERO = {DBC_W{1'b0}};
    localparam logic [DBC_W-1:0] CNT_ONE  = {{(DBC_W-1){1'b0}}, 1'b1};
    localparam logic [DBC_W-1:0] CNT_MAX  = {DBC_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic [DBC_W-1:0]       cnt_r;
    logic                   level_r;
    logic                   sync_s;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign level  = level_r;

    // Metastability synchroniser chain for the raw pad input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= {SYNC_STAGES{I2C_IDLE}};
        end else if (!srstn) begin
            sync_r <= {SYNC_STAGES{I2C_IDLE}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
        end
    end

    // Debounce counter and filtered level. The threshold compare uses >= so
    // that lowering debounce_cnt below a count already in flight applies on
    // the next compare instead of leaving the counter stuck until saturation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r   <= CNT_ZERO;
            level_r <= I2C_IDLE;
        end else if (!srstn) begin
            cnt_r   <= CNT_ZERO;
            level_r <= I2C_IDLE;
        end else if (sync_s == level_r) begin
            cnt_r   <= CNT_ZERO;
            level_r <= level_r;
        end else if (cnt_r >= debounce_cnt) begin
            cnt_r   <= CNT_ZERO;
            level_r <= sync_s;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r   <= cnt_r + CNT_ONE;
            level_r <= level_r;
        end else begin
            cnt_r   <= cnt_r;
            level_r <= level_r;
        end
    end

endmodule

// File: rtl/i2c_bus_mon.sv
// ---------------------------------------------------------------------------
// i2c_bus_mon
// Front-end monitor between the I2C pads and i2c_core. Filters SCL/SDA and
// derives SCL edge strobes, START/STOP pulses, bus-busy state and master
// arbitration loss. All strobes are registered one-cycle pulses asserted the
// cycle after the filtered edge that causes them.
//
// Optional feature macro: I2C_BUS_TIMEOUT_EN
//   When defined, adds tout_cnt/bus_tout and an SCL-low timeout counter whose
//   expiry pulses bus_tout once and clears bus_busy.
//
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   srstn           synchronous active-low soft reset
//   scl_i, sda_i    raw pad inputs
//   debounce_cnt    debounce stability cycles
//   mst_act         core is acting as master
//   sda_oe          core pulls SDA low (1 = drive 0)
//   tout_cnt        SCL-low timeout limit, 0 disables (timeout builds only)
//   bus_tout        timeout pulse (timeout builds only)
//   scl_f, sda_f    filtered levels
//   scl_rise/fall   SCL edge strobes
//   sta_det/sto_det START / STOP pulses
//   bus_busy        bus held between START and STOP
//   arb_lost        arbitration-loss pulse
// ---------------------------------------------------------------------------
module i2c_bus_mon
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int DBC_W       = I2C_DBC_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             srstn,
    input  logic             scl_i,
    input  logic             sda_i,
    input  logic [DBC_W-1:0] debounce_cnt,
    input  logic             mst_act,
    input  logic             sda_oe,
`ifdef I2C_BUS_TIMEOUT_EN
    input  logic [31:0]      tout_cnt,
    output logic             bus_tout,
`endif
    output logic             scl_f,
    output logic             sda_f,
    output logic             scl_rise,
    output logic             scl_fall,
    output logic             sta_det,
    output logic             sto_det,
    output logic             bus_busy,
    output logic             arb_lost
);

    logic scl_prev_r, sda_prev_r;
    logic scl_rise_r, scl_fall_r, sta_det_r, sto_det_r, bus_busy_r, arb_lost_r;
    logic rise_s, fall_s, scl_stable_hi_s, sta_s, sto_s, arb_s, tout_clr_s;

    i2c_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DBC_W       (DBC_W)
    ) u_scl_filt (
        .clk          (clk),
        .rstn         (rstn),
        .srstn        (srstn),
        .din          (scl_i),
        .debounce_cnt (debounce_cnt),
        .level        (scl_f)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .DBC_W       (DBC_W)
    ) u_sda_filt (
        .clk          (clk),
        .rstn         (rstn),
        .srstn        (srstn),
        .din          (sda_i),
        .debounce_cnt (debounce_cnt),
        .level        (sda_f)
    );

    // START/STOP need SCL high both now and last cycle, so a simultaneous
    // SCL and SDA change is never taken as a bus condition.
    assign rise_s          = scl_f & ~scl_prev_r;
    assign fall_s          = ~scl_f & scl_prev_r;
    assign scl_stable_hi_s = scl_f & scl_prev_r;
    assign sta_s           = scl_stable_hi_s & ~sda_f & sda_prev_r;
    assign sto_s           = scl_stable_hi_s & sda_f & ~sda_prev_r;
    // Lost if we released SDA but it reads low at SCL rise, or if a STOP
    // appears while we are still pulling SDA low.
    assign arb_s           = (rise_s & mst_act & ~sda_oe & ~sda_f) |
                             (sto_s & mst_act & sda_oe);

    // Edge history, registered strobes and bus-busy tracking.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_prev_r <= I2C_IDLE;
            sda_prev_r <= I2C_IDLE;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            sta_det_r  <= 1'b0;
            sto_det_r  <= 1'b0;
            arb_lost_r <= 1'b0;
            bus_busy_r <= 1'b0;
        end else if (!srstn) begin
            scl_prev_r <= I2C_IDLE;
            sda_prev_r <= I2C_IDLE;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            sta_det_r  <= 1'b0;
            sto_det_r  <= 1'b0;
            arb_lost_r <= 1'b0;
            bus_busy_r <= 1'b0;
        end else begin
            scl_prev_r <= scl_f;
            sda_prev_r <= sda_f;
            scl_rise_r <= rise_s;
            scl_fall_r <= fall_s;
            sta_det_r  <= sta_s;
            sto_det_r  <= sto_s;
            arb_lost_r <= arb_s;
            if (sto_det_r || tout_clr_s) begin
                bus_busy_r <= 1'b0;
            end else if (sta_det_r) begin
                bus_busy_r <= 1'b1;
            end else begin
                bus_busy_r <= bus_busy_r;
            end
        end
    end

`ifdef I2C_BUS_TIMEOUT_EN
    logic [31:0] tout_r;
    logic        bus_tout_r;

    // SCL-low timeout: counts low cycles, pulses once on reaching the limit,
    // then holds until SCL returns high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tout_r     <= 32'd0;
            bus_tout_r <= 1'b0;
        end else if (!srstn) begin
            tout_r     <= 32'd0;
            bus_tout_r <= 1'b0;
        end else if (scl_f) begin
            tout_r     <= 32'd0;
            bus_tout_r <= 1'b0;
        end else if ((tout_cnt != 32'd0) && (tout_r < tout_cnt)) begin
            tout_r     <= tout_r + 32'd1;
            bus_tout_r <= ((tout_r + 32'd1) == tout_cnt);
        end else begin
            tout_r     <= tout_r;
            bus_tout_r <= 1'b0;
        end
    end

    assign bus_tout   = bus_tout_r;
    assign tout_clr_s = bus_tout_r;
`else
    assign tout_clr_s = 1'b0;
`endif

    assign scl_rise = scl_rise_r;
    assign scl_fall = scl_fall_r;
    assign sta_det  = sta_det_r;
    assign sto_det  = sto_det_r;
    assign arb_lost = arb_lost_r;
    assign bus_busy = bus_busy_r;

endmodule
